// File: rtl/mhvpis_vec_if.sv
// Handshake and status bundle between interrupt controller and control unit.
// The slave side is the controller; the master side is the CPU/source side.
interface mhvpis_vec_if #(
    parameter int N_ITR  = 4,
    parameter int ID_W   = 2,
    parameter int ADDR_W = 8
) ();
    logic              itr_en;
    logic [N_ITR-1:0]  itr_in;
    logic              mask_wr;
    logic [N_ITR-1:0]  mask_in;
    logic              pend_clr;
    logic              itr_ack;
    logic              itr_eoi;
    logic              i_pending;
    logic [ADDR_W-1:0] PC_out;
    logic [ID_W-1:0]   itr_id;
    logic [N_ITR-1:0]  ITR_register;
    logic [N_ITR-1:0]  MASK_register;
    logic [N_ITR-1:0]  in_service;

    modport master (
        output itr_en, itr_in, mask_wr, mask_in, pend_clr, itr_ack, itr_eoi,
        input  i_pending, PC_out, itr_id, ITR_register, MASK_register, in_service
    );

    modport slave (
        input  itr_en, itr_in, mask_wr, mask_in, pend_clr, itr_ack, itr_eoi,
        output i_pending, PC_out, itr_id, ITR_register, MASK_register, in_service
    );
endinterface

// File: rtl/mhvpis_vec.sv
// N-channel maskable vectorised priority interrupt controller with sticky
// pending bits, edge/level detection and a request/ack/EOI handshake.
module mhvpis_vec #(
    parameter int                N_ITR      = 4,
    parameter int                ID_W       = 2,
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 8'h40,
    parameter logic [ADDR_W-1:0] VEC_STRIDE = 8'h10,
    parameter logic [N_ITR-1:0]  EDGE_MODE  = 4'b1000,
    parameter logic [N_ITR-1:0]  MASK_RST   = 4'b1111
) (
    input  logic         clk,
    input  logic         clr,
    mhvpis_vec_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

    state_t            r_state, w_state_next;
    logic [N_ITR-1:0]  r_pend, w_pend_next;
    logic [N_ITR-1:0]  r_mask, r_prev;
    logic [N_ITR-1:0]  r_in_svc, w_in_svc_next;
    logic [N_ITR-1:0]  w_set, w_ack_clr, w_cand;
    logic [ID_W-1:0]   r_id, w_id_next, w_win_id;
    logic [ADDR_W-1:0] r_pc, w_pc_next, w_vec;
    logic              w_accept;

    assign w_accept = (r_state == ST_REQ) && bus.itr_ack;
    assign w_cand   = r_pend & r_mask;

    // Per-channel pending: pend_clr over new set, new set over ack-clear.
    generate
        for (genvar gi = 0; gi < N_ITR; gi++) begin : g_chan
            assign w_set[gi]       = EDGE_MODE[gi] ? (bus.itr_in[gi] & ~r_prev[gi])
                                                   : bus.itr_in[gi];
            assign w_ack_clr[gi]   = w_accept && (r_id == ID_W'(gi));
            assign w_pend_next[gi] = bus.pend_clr  ? 1'b0 :
                                     w_set[gi]     ? 1'b1 :
                                     w_ack_clr[gi] ? 1'b0 : r_pend[gi];
        end
    endgenerate

    always_comb begin
        w_win_id = '0;
        for (int i = N_ITR - 1; i >= 0; i--) begin
            if (w_cand[i]) w_win_id = ID_W'(i);
        end
    end

    // Arithmetic vector; the multiply is done at ADDR_W so it wraps naturally.
    assign w_vec = VEC_BASE + VEC_STRIDE * ADDR_W'(w_win_id);

    always_comb begin
        w_state_next  = r_state;
        w_id_next     = r_id;
        w_pc_next     = r_pc;
        w_in_svc_next = r_in_svc;
        case (r_state)
            ST_IDLE: begin
                if (bus.itr_en && (|w_cand)) begin
                    w_state_next = ST_REQ;
                    w_id_next    = w_win_id;
                    w_pc_next    = w_vec;
                end
            end
            ST_REQ: begin
                if (bus.itr_ack) begin
                    w_state_next  = ST_SERVICE;
                    w_in_svc_next = N_ITR'(1) << r_id;
                end else if (!bus.itr_en || bus.pend_clr || !r_mask[r_id]) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.itr_eoi) begin
                    w_state_next  = ST_IDLE;
                    w_in_svc_next = '0;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state  <= ST_IDLE;
            r_pend   <= '0;
            r_mask   <= MASK_RST;
            r_prev   <= '0;
            r_id     <= '0;
            r_pc     <= '0;
            r_in_svc <= '0;
        end else begin
            r_state  <= w_state_next;
            r_pend   <= w_pend_next;
            r_prev   <= bus.itr_in;
            r_id     <= w_id_next;
            r_pc     <= w_pc_next;
            r_in_svc <= w_in_svc_next;
            if (bus.mask_wr) r_mask <= bus.mask_in;
        end
    end

    assign bus.i_pending     = (r_state == ST_REQ);
    assign bus.PC_out        = r_pc;
    assign bus.itr_id        = r_id;
    assign bus.ITR_register  = r_pend;
    assign bus.MASK_register = r_mask;
    assign bus.in_service    = r_in_svc;
endmodule
